// File: rtl/tpmem_pingpong_nxn_pkg.sv
// tpmem_pingpong_nxn_pkg: shared constants for the ping-pong transpose memory
package tpmem_pingpong_nxn_pkg;
    localparam int BW_DEF = 11;
    localparam int N_DEF = 16;
    typedef enum logic {MODE_PASS = 1'b0, MODE_TRANS = 1'b1} mode_e;
endpackage

// File: rtl/tpmem_bank.sv
// tpmem_bank: NxN sample array with a row write port and a row/column read mux
module tpmem_bank
    import tpmem_pingpong_nxn_pkg::*;
#(
    parameter int BW = BW_DEF,
    parameter int N = N_DEF,
    localparam int LOGN = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            wr_en,
    input  logic [LOGN-1:0] wr_row,
    input  logic [N*BW-1:0] wr_data,
    input  logic [LOGN-1:0] rd_idx,
    input  mode_e           rd_mode,
    output logic [N*BW-1:0] rd_data
);
    logic [BW-1:0] mem [N][N];

    always_ff @(posedge i_clk)
        if (wr_en)
            for (int c = 0; c < N; c++)
                mem[wr_row][c] <= wr_data[(N-1-c)*BW +: BW];

    always_comb
        for (int r = 0; r < N; r++)
            rd_data[(N-1-r)*BW +: BW] = rd_mode == MODE_TRANS ? mem[r][rd_idx] : mem[rd_idx][r];
endmodule

// File: rtl/tpmem_pingpong_nxn.sv
// tpmem_pingpong_nxn: double-buffered NxN transpose memory with output handshake
module tpmem_pingpong_nxn
    import tpmem_pingpong_nxn_pkg::*;
#(
    parameter int BW = BW_DEF,
    parameter int N = N_DEF,
    localparam int LOGN = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic [N*BW-1:0] i_data,
    input  logic            i_enable,
    input  logic            i_mode,
    input  logic            i_ready,
    output logic [N*BW-1:0] o_data,
    output logic            o_en,
    output logic            o_busy,
    output logic            o_err
);
    logic [1:0]      full, full_n;
    logic            wb, rb;
    logic [LOGN-1:0] wr_cnt, rd_cnt;
    mode_e           bank_mode [2];
    logic [N*BW-1:0] bank_rd [2];
    logic            wr_fire, wr_last, ld, rd_fire, rd_last;

    assign wr_fire = i_enable && !full[wb];
    assign wr_last = wr_fire && wr_cnt == LOGN'(N-1);
    assign ld      = !o_en || i_ready;
    assign rd_fire = ld && full[rb];
    assign rd_last = rd_fire && rd_cnt == LOGN'(N-1);
    assign o_busy  = full[wb];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tpmem_bank #(.BW(BW), .N(N)) u_bank (
            .i_clk   (i_clk),
            .wr_en   (wr_fire && wb == 1'(b)),
            .wr_row  (wr_cnt),
            .wr_data (i_data),
            .rd_idx  (rd_cnt),
            .rd_mode (bank_mode[b]),
            .rd_data (bank_rd[b])
        );
    end

    // Write and read completions can land on the same edge; they touch different banks.
    always_comb begin
        full_n = full;
        if (rd_last) full_n[rb] = 1'b0;
        if (wr_last) full_n[wb] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_Reset) begin
            full         <= '0;
            wb           <= 1'b0;
            rb           <= 1'b0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            bank_mode[0] <= MODE_PASS;
            bank_mode[1] <= MODE_PASS;
            o_data       <= '0;
            o_en         <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            full <= full_n;
            if (i_enable && full[wb])
                o_err <= 1'b1;
            if (wr_fire)
                wr_cnt <= wr_cnt + LOGN'(1);
            if (wr_last) begin
                bank_mode[wb] <= mode_e'(i_mode);
                wb            <= ~wb;
            end
            if (ld) begin
                o_en   <= full[rb];
                o_data <= full[rb] ? bank_rd[rb] : '0;
            end
            if (rd_fire)
                rd_cnt <= rd_cnt + LOGN'(1);
            if (rd_last)
                rb <= ~rb;
        end
    end
endmodule

// File: tb/tb_tpmem_pingpong_nxn.sv
// tb_tpmem_pingpong_nxn: scoreboard bench for the ping-pong transpose memory
module tb_tpmem_pingpong_nxn;
    localparam int N = 16;
    localparam int BW = 11;
    localparam int W = N * BW;

    logic         i_clk = 1'b0;
    logic         i_Reset = 1'b0;
    logic [W-1:0] i_data = '0;
    logic         i_enable = 1'b0;
    logic         i_mode = 1'b0;
    logic         i_ready = 1'b1;
    logic [W-1:0] o_data;
    logic         o_en, o_busy, o_err;

    tpmem_pingpong_nxn #(.BW(BW), .N(N)) dut (
        .i_clk    (i_clk),
        .i_Reset  (i_Reset),
        .i_data   (i_data),
        .i_enable (i_enable),
        .i_mode   (i_mode),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_en     (o_en),
        .o_busy   (o_busy),
        .o_err    (o_err)
    );

    always #5 i_clk = ~i_clk;

    int           n_chk = 0, n_fail = 0;
    logic [W-1:0] q [$];
    bit           mon_on = 1'b0;
    bit           busy_seen = 1'b0;
    int           run = 0, last_run = 0, popc = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] lane(input logic [W-1:0] row, input int c);
        return row[(N-1-c)*BW +: BW];
    endfunction

    function automatic logic [W-1:0] mkrow(input int seed, input int r);
        logic [W-1:0] row;
        for (int c = 0; c < N; c++)
            row[(N-1-c)*BW +: BW] = BW'(seed + r * N + c);
        return row;
    endfunction

    // Outputs are consumed on the posedge following a negedge that shows o_en && i_ready.
    always @(negedge i_clk) begin
        if (mon_on) begin
            if (o_busy) busy_seen = 1'b1;
            if (o_en) run++;
            else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (!o_en)
                chk("idle_zero", o_data, '0);
            else if (i_ready) begin
                popc++;
                if (q.size() == 0)
                    chk("unexpected_out", o_data, 'x);
                else
                    chk("out_data", o_data, q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic push_block(input int seed, input bit m);
        logic [W-1:0] e;
        for (int k = 0; k < N; k++) begin
            for (int r = 0; r < N; r++)
                e[(N-1-r)*BW +: BW] = m ? lane(mkrow(seed, r), k) : lane(mkrow(seed, k), r);
            q.push_back(e);
        end
    endtask

    task automatic send_block(input int seed, input bit m, input bit gap);
        for (int r = 0; r < N; r++) begin
            i_data = mkrow(seed, r);
            i_enable = 1'b1;
            i_mode = m;
            tick();
            if (gap && r != N - 1) begin
                i_enable = 1'b0;
                i_data = '1;
                tick();
            end
        end
        i_enable = 1'b0;
        i_data = '0;
        push_block(seed, m);
    endtask

    task automatic drain();
        int i = 0;
        while (q.size() > 0 && i < 600) begin
            tick();
            i++;
        end
        chk("drain_left", W'(q.size()), '0);
        repeat (3) tick();
        chk("drain_en", W'(o_en), '0);
    endtask

    initial begin
        logic [W-1:0] held;
        int i;
        repeat (3) tick();
        chk("rst_data", o_data, '0);
        chk("rst_en", W'(o_en), '0);
        chk("rst_busy", W'(o_busy), '0);
        chk("rst_err", W'(o_err), '0);
        i_Reset = 1'b1;
        mon_on = 1'b1;
        tick();

        send_block(0, 1'b1, 1'b0);
        chk("lat_pre", W'(o_en), '0);
        tick();
        chk("lat_post", W'(o_en), W'(1));
        drain();
        chk("trans_run", W'(last_run), W'(N));

        send_block(0, 1'b0, 1'b0);
        drain();
        chk("pass_run", W'(last_run), W'(N));

        busy_seen = 1'b0;
        send_block(11, 1'b1, 1'b0);
        send_block(22, 1'b0, 1'b0);
        send_block(33, 1'b1, 1'b0);
        drain();
        chk("stream_run", W'(last_run), W'(3 * N));
        chk("stream_busy", W'(busy_seen), '0);

        send_block(7, 1'b1, 1'b1);
        repeat (3) tick();
        i_ready = 1'b0;
        held = o_data;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_data", o_data, held);
            chk("stall_en", W'(o_en), W'(1));
        end
        i_ready = 1'b1;
        drain();

        i_ready = 1'b0;
        send_block(40, 1'b1, 1'b0);
        chk("ovf_busy16", W'(o_busy), '0);
        send_block(80, 1'b0, 1'b0);
        chk("ovf_busy32", W'(o_busy), W'(1));
        chk("ovf_err_pre", W'(o_err), '0);
        i_data = mkrow(120, 0);
        i_enable = 1'b1;
        tick();
        i_enable = 1'b0;
        chk("ovf_err", W'(o_err), W'(1));
        i_ready = 1'b1;
        drain();
        chk("ovf_err_sticky", W'(o_err), W'(1));

        popc = 0;
        send_block(3, 1'b1, 1'b0);
        i = 0;
        while (popc < 4 && i < 100) begin
            tick();
            i++;
        end
        chk("rst_wait", W'(popc), W'(4));
        mon_on = 1'b0;
        i_Reset = 1'b0;
        tick();
        chk("mrst_data", o_data, '0);
        chk("mrst_en", W'(o_en), '0);
        chk("mrst_busy", W'(o_busy), '0);
        chk("mrst_err", W'(o_err), '0);
        q.delete();
        run = 0;
        i_Reset = 1'b1;
        tick();
        mon_on = 1'b1;
        send_block(100, 1'b1, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
